// File: rtl/eu_param.sv
// eu_param: parametrised execution unit. It fetches A/B over the shared bus, runs one ALU op and writes R back.
// Status flags {V,N,C,Z} are built only when EU_FLAGS_EN is defined; otherwise flags read 4'b0000.
module eu_param #(
  parameter int DW   = 16,
  parameter int IMMW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ir,
  input  logic          start,
  input  logic [1:0]    mode,
  inout  logic [DW-1:0] bus,
  output logic          biu_req,
  output logic [1:0]    biu_op,
  input  logic          biu_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    flags
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state_r, state_s;
  logic [31:0]   ir_r;
  logic [1:0]    mode_r;
  logic [DW-1:0] a_r, b_r, res_r, res_s, imm_ext_s;
  logic          req_r, busy_r, done_r, err_r, drive_r, illegal_s;
  logic [1:0]    op_r;
  logic [2:0]    opc_s;
  logic          unused_ir_s;

  assign opc_s       = ir_r[18:16];
  assign illegal_s   = (state_r == S_IDLE) && start && (mode == 2'b11);
  assign unused_ir_s = ^ir_r;

  // immediate extension; upper bits copy ir[19] & imm MSB (sign) or zero
  always_comb begin
    for (int i = 0; i < DW; i++) begin
      if (i < IMMW) imm_ext_s[i] = ir_r[i];
      else          imm_ext_s[i] = ir_r[19] & ir_r[IMMW-1];
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: if (start) state_s = (mode == 2'b11) ? S_DONE : S_RDA;
              else       state_s = S_IDLE;
      S_RDA:  if (biu_ready) state_s = (mode_r == 2'b01) ? S_RDB : S_EXEC;
              else           state_s = S_RDA;
      S_RDB:  if (biu_ready) state_s = S_EXEC;
              else           state_s = S_RDB;
      S_EXEC: state_s = S_WR;
      S_WR:   if (biu_ready) state_s = S_DONE;
              else           state_s = S_WR;
      S_DONE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // result datapath; shifts of DW or more naturally give zero
  always_comb begin
    res_s = {DW{1'b0}};
    case (opc_s)
      3'b000: res_s = a_r + b_r;
      3'b001: res_s = a_r - b_r;
      3'b010: res_s = a_r & b_r;
      3'b011: res_s = a_r | b_r;
      3'b100: res_s = a_r ^ b_r;
      3'b101: res_s = ~a_r;
      3'b110: res_s = a_r << b_r[4:0];
      3'b111: res_s = a_r >> b_r[4:0];
      default: res_s = {DW{1'b0}};
    endcase
  end

  // control, handshake and operand registers; all outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      ir_r    <= 32'h0000_0000;
      mode_r  <= 2'b00;
      a_r     <= {DW{1'b0}};
      b_r     <= {DW{1'b0}};
      res_r   <= {DW{1'b0}};
      req_r   <= 1'b0;
      op_r    <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      drive_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE);
      err_r   <= illegal_s;
      drive_r <= (state_s == S_WR);
      req_r   <= (state_s == S_RDA) || (state_s == S_RDB) || (state_s == S_WR);
      case (state_s)
        S_RDB:   op_r <= 2'b01;
        S_WR:    op_r <= 2'b10;
        default: op_r <= 2'b00;
      endcase
      if ((state_r == S_IDLE) && start) begin
        ir_r   <= ir;
        mode_r <= mode;
      end
      if ((state_r == S_RDA) && biu_ready) begin
        a_r <= bus;
        b_r <= (mode_r == 2'b00) ? imm_ext_s : {DW{1'b0}};
      end
      if ((state_r == S_RDB) && biu_ready) b_r <= bus;
      if (state_r == S_EXEC) res_r <= res_s;
    end
  end

`ifdef EU_FLAGS_EN
  logic [3:0]  flags_r;
  logic [31:0] n32_s;
  logic        c_s, v_s;

  // carry/borrow recovered from operand and result MSBs; shift carry is the last bit pushed out
  always_comb begin
    n32_s = {27'd0, b_r[4:0]};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (opc_s)
      3'b000: begin
        c_s = (a_r[DW-1] & b_r[DW-1]) | ((a_r[DW-1] ^ b_r[DW-1]) & ~res_s[DW-1]);
        v_s = (a_r[DW-1] == b_r[DW-1]) && (res_s[DW-1] != a_r[DW-1]);
      end
      3'b001: begin
        c_s = (~a_r[DW-1] & b_r[DW-1]) | (~(a_r[DW-1] ^ b_r[DW-1]) & res_s[DW-1]);
        v_s = (a_r[DW-1] != b_r[DW-1]) && (res_s[DW-1] != a_r[DW-1]);
      end
      3'b110: for (int i = 0; i < DW; i++) c_s = c_s | (a_r[i] & (n32_s == DW - i));
      3'b111: for (int i = 0; i < DW; i++) c_s = c_s | (a_r[i] & (n32_s == i + 1));
      default: begin
        c_s = 1'b0;
        v_s = 1'b0;
      end
    endcase
  end

  // flags change only on the EXEC edge
  always_ff @(posedge clk) begin
    if (rst)                    flags_r <= 4'b0000;
    else if (state_r == S_EXEC) flags_r <= {v_s, res_s[DW-1], c_s, (res_s == {DW{1'b0}})};
  end

  assign flags = flags_r;
`else
  assign flags = 4'b0000;
`endif

  assign bus     = drive_r ? res_r : {DW{1'bz}};
  assign biu_req = req_r;
  assign biu_op  = op_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_eu_param.sv
// Scoreboard bench for eu_param (DW=16, IMMW=8): a BIU model serves reads/writes with programmable waits,
// a monitor pops expected results on every done pulse and checks data, flags, err and latency.
module tb_eu_param;
  localparam int DW   = 16;
  localparam int IMMW = 8;
`ifdef EU_FLAGS_EN
  localparam logic [3:0] FMASK = 4'b1111;
`else
  localparam logic [3:0] FMASK = 4'b0000;
`endif

  logic          clk = 1'b0;
  logic          rst, start, biu_req, biu_ready, busy, done, err;
  logic [31:0]   ir;
  logic [1:0]    mode, biu_op;
  logic [3:0]    flags;
  wire  [DW-1:0] bus;
  logic          tb_drv;
  logic [DW-1:0] tb_data;

  assign bus = tb_drv ? tb_data : {DW{1'bz}};
  always #5 clk = ~clk;

  eu_param #(.DW(DW), .IMMW(IMMW)) dut (
    .clk(clk), .rst(rst), .ir(ir), .start(start), .mode(mode), .bus(bus),
    .biu_req(biu_req), .biu_op(biu_op), .biu_ready(biu_ready),
    .busy(busy), .done(done), .err(err), .flags(flags)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [3:0]    flg;
    logic          er;
    int            lat;
    int            scyc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0, errors = 0, cyc = 0, n_done = 0;
  int            dly_a = 0, dly_b = 0, dly_w = 0, cnt = 0;
  logic [DW-1:0] val_a = 16'h0000, val_b = 16'h0000, wr_val = 16'h0000;
  logic          wr_seen = 1'b0, prev_req = 1'b0, stray_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic sx, input logic [2:0] op, input logic [15:0] imm);
    return {12'h000, sx, op, imm};
  endfunction

  always @(posedge clk) cyc++;

  // BIU model: answers a request after the programmed number of wait cycles
  always @(negedge clk) begin
    int lim;
    if (prev_req && biu_ready) cnt = 0;
    if (rst) begin
      biu_ready = 1'b0; tb_drv = 1'b0; cnt = 0; wr_seen = 1'b0;
    end else if (biu_req) begin
      lim = (biu_op == 2'b00) ? dly_a : (biu_op == 2'b01) ? dly_b : dly_w;
      if (cnt >= lim) begin
        biu_ready = 1'b1;
        tb_drv    = (biu_op != 2'b10);
        tb_data   = (biu_op == 2'b00) ? val_a : val_b;
        if (biu_op == 2'b10) begin
          wr_val  = bus;
          wr_seen = 1'b1;
        end
      end else begin
        biu_ready = 1'b0;
        tb_drv    = 1'b0;
      end
      cnt++;
    end else begin
      biu_ready = stray_ready;
      tb_drv    = 1'b0;
      cnt       = 0;
    end
    prev_req = biu_req;
  end

  // monitor: pops the scoreboard on each done pulse
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!tb_drv && !(biu_req && biu_op == 2'b10)) chk("bus_idle_z", {31'd0, bus === {DW{1'bz}}}, 32'd1);
    if (!rst) begin
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.er});
          chk("latency", cyc - e.scyc + 1, e.lat);
          chk("flags", {28'd0, flags}, {28'd0, e.flg & FMASK});
          if (e.er) begin
            chk("no_write", {31'd0, wr_seen}, 32'd0);
          end else begin
            chk("write_seen", {31'd0, wr_seen}, 32'd1);
            chk("wr_data", {16'd0, wr_val}, {16'd0, e.res});
          end
          wr_seen = 1'b0;
        end
      end else begin
        chk("err_alone", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic run(input logic [1:0] md, input logic [31:0] irv, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input int da, input int db, input int dw,
                     input logic [DW-1:0] res, input logic [3:0] flg, input logic er, input int lat);
    exp_t e;
    int   tgt;
    val_a = a; val_b = b; dly_a = da; dly_b = db; dly_w = dw;
    @(negedge clk);
    e.res = res; e.flg = flg; e.er = er; e.lat = lat; e.scyc = cyc;
    exp_q.push_back(e);
    tgt   = n_done + 1;
    start = 1'b1; ir = irv; mode = md;
    @(negedge clk);
    ir = ~irv; mode = 2'b11;          // held start and new ir/mode while busy must be ignored
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && n_done < tgt; k++) @(negedge clk);
    if (n_done < tgt) begin
      chk("timeout_done", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ir = 32'h0; mode = 2'b00; biu_ready = 1'b0; tb_drv = 1'b0; tb_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, biu_req}, 32'd0);
    chk("rst_op", {30'd0, biu_op}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_bus_z", {31'd0, bus === {DW{1'bz}}}, 32'd1);
    rst = 1'b0;

    //  mode   ir                          A         B         da db dw  R         VNCZ     err lat
    run(2'b00, mk(1'b0, 3'b000, 16'h0005), 16'h1234, 16'h0000, 0, 0, 0, 16'h1239, 4'b0000, 1'b0, 5);
    run(2'b01, mk(1'b0, 3'b001, 16'h0000), 16'h0003, 16'h0005, 0, 2, 0, 16'hFFFE, 4'b0110, 1'b0, 8);
    run(2'b00, mk(1'b1, 3'b000, 16'h00FF), 16'h0001, 16'h0000, 0, 0, 0, 16'h0000, 4'b0011, 1'b0, 5);
    run(2'b00, mk(1'b0, 3'b010, 16'hA5FF), 16'h1234, 16'h0000, 0, 0, 0, 16'h0034, 4'b0000, 1'b0, 5);
    run(2'b00, mk(1'b1, 3'b011, 16'h0080), 16'h0001, 16'h0000, 0, 0, 0, 16'hFF81, 4'b0100, 1'b0, 5);
    run(2'b10, mk(1'b0, 3'b110, 16'h00FF), 16'h8001, 16'h1234, 0, 0, 0, 16'h8001, 4'b0100, 1'b0, 5);
    run(2'b01, mk(1'b0, 3'b110, 16'h0000), 16'h8001, 16'h0001, 0, 0, 0, 16'h0002, 4'b0010, 1'b0, 6);
    run(2'b01, mk(1'b0, 3'b000, 16'h0000), 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 4'b1100, 1'b0, 6);
    run(2'b01, mk(1'b0, 3'b111, 16'h0000), 16'h800F, 16'h0004, 0, 0, 0, 16'h0800, 4'b0010, 1'b0, 6);
    run(2'b01, mk(1'b0, 3'b111, 16'h0000), 16'h8001, 16'h0010, 0, 0, 0, 16'h0000, 4'b0011, 1'b0, 6);
    run(2'b01, mk(1'b0, 3'b110, 16'h0000), 16'h0001, 16'h0021, 0, 0, 0, 16'h0002, 4'b0000, 1'b0, 6);
    run(2'b10, mk(1'b0, 3'b101, 16'h0000), 16'h00FF, 16'h0000, 1, 0, 2, 16'hFF00, 4'b0100, 1'b0, 8);
    run(2'b01, mk(1'b0, 3'b100, 16'h0000), 16'hF0F0, 16'hFF00, 0, 0, 0, 16'h0FF0, 4'b0000, 1'b0, 6);
    run(2'b01, mk(1'b0, 3'b001, 16'h0000), 16'h8000, 16'h0001, 0, 0, 0, 16'h7FFF, 4'b1000, 1'b0, 6);
    run(2'b01, mk(1'b0, 3'b011, 16'h0000), 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001, 1'b0, 6);
    stray_ready = 1'b1;
    run(2'b11, mk(1'b0, 3'b000, 16'h0000), 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001, 1'b1, 2);
    repeat (3) @(negedge clk);
    stray_ready = 1'b0;

    // abort in WR: bus released and state cleared on the reset edge, no done
    val_a = 16'h0100; dly_a = 0; dly_w = 6;
    @(negedge clk);
    start = 1'b1; ir = mk(1'b0, 3'b000, 16'h0001); mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !(biu_req && biu_op == 2'b10); k++) @(negedge clk);
    chk("abort_in_wr", {31'd0, biu_req && biu_op == 2'b10}, 32'd1);
    chk("abort_bus_driven", {16'd0, bus}, 32'h0000_0101);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bus_z", {31'd0, bus === {DW{1'bz}}}, 32'd1);
    chk("abort_req", {31'd0, biu_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    rst = 1'b0; dly_w = 0;
    repeat (4) @(negedge clk);
    run(2'b00, mk(1'b0, 3'b000, 16'h0010), 16'h0020, 16'h0000, 0, 0, 0, 16'h0030, 4'b0000, 1'b0, 5);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
